// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, decode helpers and shared types for the execute stage
package alu_pkg;
   localparam int ALU_DATA_W = 32;

   localparam logic [6:0] OP_ADD  = 7'h01;
   localparam logic [6:0] OP_SUB  = 7'h02;
   localparam logic [6:0] OP_ADDI = 7'h03;
   localparam logic [6:0] OP_MUL  = 7'h04;
   localparam logic [6:0] OP_LD   = 7'h10;
   localparam logic [6:0] OP_LDB  = 7'h11;
   localparam logic [6:0] OP_ST   = 7'h12;
   localparam logic [6:0] OP_STB  = 7'h13;
   localparam logic [6:0] OP_BEQ  = 7'h20;
   localparam logic [6:0] OP_JUMP = 7'h21;

   typedef enum logic {BYTE, WORD} mem_size_t;

   typedef struct packed {
      logic [ALU_DATA_W-1:0] addr;
      logic [ALU_DATA_W-1:0] data;
      mem_size_t             size;
      logic                  is_store;
   } dcache_request_t;

   typedef enum logic [1:0] {IDLE, MUL_BUSY, MUL_DONE} alu_state_t;

   function automatic logic is_load(input logic [6:0] op);
      return op == OP_LD || op == OP_LDB;
   endfunction

   function automatic logic is_m_type(input logic [6:0] op);
      return is_load(op) || op == OP_ST || op == OP_STB;
   endfunction

   function automatic logic is_r_type(input logic [6:0] op);
      return op == OP_ADD || op == OP_SUB || op == OP_ADDI || op == OP_MUL;
   endfunction
endpackage

// File: rtl/alu_mul_unit.sv
// alu_mul_unit: captures MUL operands on start, counts MUL_LATENCY cycles,
// then holds the product with a done flag until the top clears it
module alu_mul_unit
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int MUL_LATENCY = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  clear,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic                  last,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] product
);
   localparam int CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

   logic [DATA_WIDTH-1:0] op_a, op_b;
   logic [CNT_W-1:0]      cnt;
   logic                  busy;

   assign last    = busy && cnt == CNT_W'(MUL_LATENCY - 1);
   assign product = op_a * op_b;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         op_a <= '0;
         op_b <= '0;
         cnt  <= '0;
         busy <= 1'b0;
         done <= 1'b0;
      end else if (start) begin
         op_a <= a;
         op_b <= b;
         cnt  <= '0;
         busy <= 1'b1;
         done <= 1'b0;
      end else if (busy) begin
         cnt  <= last ? cnt : cnt + 1'b1;
         busy <= !last;
         done <= last && !clear;
      end else if (clear) begin
         done <= 1'b0;
      end
   end
endmodule

// File: rtl/alu_exec_pipe.sv
// alu_exec_pipe: execute stage with valid/ready on both sides and a multi-cycle MUL.
// Define ALU_BYPASS_EN to add the late-stage operand forwarding ports.
module alu_exec_pipe
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int PC_WIDTH    = 32,
   parameter int RF_ADDR_W   = 5,
   parameter int OFFSET_W    = 15,
   parameter int MUL_LATENCY = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [6:0]            in_opcode,
   input  logic [RF_ADDR_W-1:0]  in_ra_addr,
   input  logic [RF_ADDR_W-1:0]  in_rd_addr,
   input  logic [DATA_WIDTH-1:0] in_ra_data,
   input  logic [DATA_WIDTH-1:0] in_rb_data,
   input  logic [OFFSET_W-1:0]   in_offset,
   input  logic [PC_WIDTH-1:0]   in_pc,
`ifdef ALU_BYPASS_EN
   input  logic [RF_ADDR_W-1:0]  in_rb_addr,
   input  logic                  bp_valid,
   input  logic [RF_ADDR_W-1:0]  bp_dst_reg,
   input  logic [DATA_WIDTH-1:0] bp_data,
`endif
   output logic                  out_valid,
   input  logic                  out_ready,
   output dcache_request_t       out_req,
   output logic                  out_m_type,
   output logic                  out_r_type,
   output logic [RF_ADDR_W-1:0]  out_dst_reg,
   output logic [PC_WIDTH-1:0]   out_pc,
   output logic                  take_branch,
   output logic [PC_WIDTH-1:0]   branch_pc,
   output logic                  mul_busy
);
   alu_state_t            state;
   dcache_request_t       req_n;
   logic                  free, accept, is_mul, alu_load, mul_load, mul_last, mul_done, taken_n;
   logic [DATA_WIDTH-1:0] ra, rb, zx_off, product;
   logic [PC_WIDTH-1:0]   zx_pc, mul_pc;
   logic [RF_ADDR_W-1:0]  mul_rd;

`ifdef ALU_BYPASS_EN
   assign ra = (bp_valid && bp_dst_reg == in_ra_addr) ? bp_data : in_ra_data;
   assign rb = (bp_valid && bp_dst_reg == in_rb_addr) ? bp_data : in_rb_data;
`else
   logic unused_ra_addr;
   assign unused_ra_addr = ^in_ra_addr;
   assign ra = in_ra_data;
   assign rb = in_rb_data;
`endif

   assign zx_off   = {{(DATA_WIDTH-OFFSET_W){1'b0}}, in_offset};
   assign zx_pc    = {{(PC_WIDTH-OFFSET_W){1'b0}}, in_offset};
   assign free     = !out_valid || out_ready;
   assign in_ready = reset && state == IDLE && free;
   assign accept   = in_valid && in_ready;
   assign is_mul   = in_opcode == OP_MUL;
   assign alu_load = accept && !is_mul;
   // MUL_DONE only matters if the output is still occupied when the count expires
   assign mul_load = free && ((state == MUL_BUSY && mul_last) || (state == MUL_DONE && mul_done));
   assign mul_busy = state != IDLE;
   assign taken_n  = in_opcode == OP_JUMP || (in_opcode == OP_BEQ && ra == rb);

   always_comb begin
      req_n          = '0;
      req_n.size     = (in_opcode == OP_LDB || in_opcode == OP_STB) ? BYTE : WORD;
      req_n.is_store = in_opcode == OP_ST || in_opcode == OP_STB;
      case (in_opcode)
         OP_ADD:        req_n.data = ra + rb;
         OP_SUB:        req_n.data = ra - rb;
         OP_ADDI:       req_n.data = ra + zx_off;
         OP_LD, OP_LDB: req_n.addr = ra + zx_off;
         OP_ST, OP_STB: begin
            req_n.addr = rb + zx_off;
            req_n.data = ra;
         end
         default: ;
      endcase
   end

   alu_mul_unit #(.DATA_WIDTH(DATA_WIDTH), .MUL_LATENCY(MUL_LATENCY)) u_mul (
      .clock   (clock),
      .reset   (reset),
      .start   (accept && is_mul),
      .clear   (mul_load),
      .a       (ra),
      .b       (rb),
      .last    (mul_last),
      .done    (mul_done),
      .product (product)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         out_valid   <= 1'b0;
         out_req     <= '0;
         out_m_type  <= 1'b0;
         out_r_type  <= 1'b0;
         out_dst_reg <= '0;
         out_pc      <= '0;
         take_branch <= 1'b0;
         branch_pc   <= '0;
         mul_rd      <= '0;
         mul_pc      <= '0;
      end else begin
         take_branch <= alu_load && taken_n;
         out_valid   <= (alu_load || mul_load) ? 1'b1 : (out_ready ? 1'b0 : out_valid);
         if (alu_load) begin
            out_req     <= req_n;
            out_m_type  <= is_m_type(in_opcode);
            out_r_type  <= is_r_type(in_opcode);
            out_dst_reg <= in_rd_addr;
            out_pc      <= in_pc;
            if (taken_n) branch_pc <= zx_pc;
         end
         if (mul_load) begin
            out_req.addr     <= '0;
            out_req.data     <= product;
            out_req.size     <= WORD;
            out_req.is_store <= 1'b0;
            out_m_type       <= 1'b0;
            out_r_type       <= 1'b1;
            out_dst_reg      <= mul_rd;
            out_pc           <= mul_pc;
         end
         if (accept && is_mul) begin
            mul_rd <= in_rd_addr;
            mul_pc <= in_pc;
         end
         case (state)
            IDLE:     state <= (accept && is_mul) ? MUL_BUSY : IDLE;
            MUL_BUSY: state <= mul_last ? (free ? IDLE : MUL_DONE) : MUL_BUSY;
            MUL_DONE: state <= free ? IDLE : MUL_DONE;
            default:  state <= IDLE;
         endcase
      end
   end
endmodule
